// File: rtl/bf16_pkg.sv
// bf16_pkg: shared field widths, special encodings and flag bit positions for the FP32->BF16 path.
// Rev 1.0
`default_nettype none
package bf16_pkg;
  localparam int FP32_EXP_W    = 8;
  localparam int FP32_FRAC_W   = 23;
  localparam int BF16_EXP_W    = 8;
  localparam int BF16_FRAC_W   = 7;
  localparam int FLG_W         = 3;

  localparam logic [7:0] EXP_ALL_ONES  = 8'hFF;
  localparam int         BF16_QNAN_BIT = 6;

  localparam int FLG_NAN = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_INX = 0;
endpackage
`default_nettype wire

// File: rtl/fp32_to_bf16_round.sv
// fp32_to_bf16_round: combinational classify + round-to-nearest-even + exception flags.
// Rev 1.0
`default_nettype none
module fp32_to_bf16_round
  import bf16_pkg::*;
#(
  parameter bit FTZ = 1'b1
) (
  input  logic [31:0]      a,
  output logic [15:0]      res,
  output logic [FLG_W-1:0] flags
);

  logic                   w_sign;
  logic [FP32_EXP_W-1:0]  w_exp;
  logic [FP32_FRAC_W-1:0] w_frac;
  logic                   w_guard;
  logic                   w_sticky;
  logic                   w_rup;
  logic [14:0]            w_mag;
  logic [BF16_FRAC_W-1:0] w_nan_frac;

  assign w_sign   = a[31];
  assign w_exp    = a[30:23];
  assign w_frac   = a[22:0];
  assign w_guard  = a[15];
  assign w_sticky = |a[14:0];
  assign w_rup    = w_guard & (w_sticky | a[16]);
  // The largest finite input rounds to at most 0x7F80, so 15 bits never wrap.
  assign w_mag    = a[30:16] + {14'd0, w_rup};

  always_comb begin
    w_nan_frac                = {1'b0, a[21:16]};
    w_nan_frac[BF16_QNAN_BIT] = 1'b1;
  end

  always_comb begin
    res            = {w_sign, w_mag};
    flags          = '0;
    flags[FLG_INX] = w_guard | w_sticky;
    if (w_exp == EXP_ALL_ONES && w_frac != '0) begin
      res            = {w_sign, EXP_ALL_ONES, w_nan_frac};
      flags          = '0;
      flags[FLG_NAN] = 1'b1;
    end else if (w_exp == EXP_ALL_ONES) begin
      res   = {w_sign, EXP_ALL_ONES, {BF16_FRAC_W{1'b0}}};
      flags = '0;
    end else if (w_exp == '0 && w_frac == '0) begin
      res   = {w_sign, 15'h0000};
      flags = '0;
    end else if (w_exp == '0 && FTZ) begin
      res            = {w_sign, 15'h0000};
      flags          = '0;
      flags[FLG_INX] = 1'b1;
    end else if (w_mag[14:7] == EXP_ALL_ONES) begin
      res            = {w_sign, EXP_ALL_ONES, {BF16_FRAC_W{1'b0}}};
      flags[FLG_OVF] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp32_to_bf16_conv.sv
// fp32_to_bf16_conv: two-stage valid/ready FP32 -> BF16 narrowing converter.
// Rev 1.0
`default_nettype none
module fp32_to_bf16_conv
  import bf16_pkg::*;
#(
  parameter bit FTZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [FLG_W-1:0] out_flags
);

  logic             r_v1;
  logic [31:0]      r_d1;
  logic             r_v2;
  logic             w_adv1;
  logic             w_adv2;
  logic [15:0]      w_rnd_data;
  logic [FLG_W-1:0] w_rnd_flags;

  assign w_adv2    = ~r_v2 | out_ready;
  assign w_adv1    = ~r_v1 | w_adv2;
  assign in_ready  = ~rst & w_adv1;
  assign out_valid = r_v2;

  fp32_to_bf16_round #(
    .FTZ   (FTZ)
  ) u_round (
    .a     (r_d1),
    .res   (w_rnd_data),
    .flags (w_rnd_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1      <= 1'b0;
      r_d1      <= '0;
      r_v2      <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else begin
      if (w_adv1) begin
        r_v1 <= in_valid;
        if (in_valid) r_d1 <= in_data;
      end
      // Output register only changes when it advances, so stalled data holds.
      if (w_adv2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          out_data  <= w_rnd_data;
          out_flags <= w_rnd_flags;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp32_to_bf16_conv.sv
// tb_fp32_to_bf16_conv: scoreboard bench driving an FTZ=1 and an FTZ=0 converter in lockstep.
// Rev 1.0
`default_nettype none
module tb_fp32_to_bf16_conv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b1;
  logic        in_ready1, in_ready0;
  logic        out_valid1, out_valid0;
  logic [15:0] out_data1, out_data0;
  logic [2:0]  out_flags1, out_flags0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int pop_cyc[$];
  logic [18:0] exp1[$];
  logic [18:0] exp0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp32_to_bf16_conv #(.FTZ(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_flags(out_flags1)
  );

  fp32_to_bf16_conv #(.FTZ(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_flags(out_flags0)
  );

  // Reference: {flags[2:0], bf16[15:0]}, rounding expressed on the remainder value.
  function automatic logic [18:0] model(input logic [31:0] a, input bit ftz);
    logic [7:0]  e;
    logic [22:0] f;
    logic [16:0] hi;
    logic [15:0] rem;
    logic        inx, ovf;
    e = a[30:23];
    f = a[22:0];
    if (e == 8'hFF && f != 0) return {3'b100, a[31], 8'hFF, 1'b1, a[21:16]};
    if (e == 8'hFF)           return {3'b000, a[31], 15'h7F80};
    if (e == 0 && f == 0)     return {3'b000, a[31], 15'h0000};
    if (e == 0 && ftz)        return {3'b001, a[31], 15'h0000};
    hi  = {1'b0, a[31:16]};
    rem = a[15:0];
    if (rem > 16'h8000 || (rem == 16'h8000 && hi[0])) hi = hi + 17'd1;
    inx = (rem != 0);
    ovf = (hi[14:7] == 8'hFF);
    return {1'b0, ovf, inx, hi[15:0]};
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid1 && out_ready) begin
      pop_cyc.push_back(cyc);
      vectors++;
      if (exp1.size() == 0) begin
        miscompares++;
        $display("FAIL out_ftz1 unexpected output got %h/%b expected none", out_data1, out_flags1);
      end else begin
        logic [18:0] e1;
        e1 = exp1.pop_front();
        if ({out_flags1, out_data1} !== e1) begin
          miscompares++;
          $display("FAIL out_ftz1 got %h/%b expected %h/%b", out_data1, out_flags1, e1[15:0], e1[18:16]);
        end
      end
    end
    if (!rst && out_valid0 && out_ready) begin
      vectors++;
      if (exp0.size() == 0) begin
        miscompares++;
        $display("FAIL out_ftz0 unexpected output got %h/%b expected none", out_data0, out_flags0);
      end else begin
        logic [18:0] e0;
        e0 = exp0.pop_front();
        if ({out_flags0, out_data0} !== e0) begin
          miscompares++;
          $display("FAIL out_ftz0 got %h/%b expected %h/%b", out_data0, out_flags0, e0[15:0], e0[18:16]);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] a);
    int n = 0;
    in_valid = 1'b1;
    in_data  = a;
    @(negedge clk);
    while (!in_ready1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready1) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout in_ready got 0 expected 1 for %h", a);
    end else begin
      last_acc_cyc = cyc;
      exp1.push_back(model(a, 1'b1));
      exp0.push_back(model(a, 1'b0));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp1.size() != 0 || exp0.size() != 0) && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    vectors++;
    if (exp1.size() != 0 || exp0.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout pending got %0d/%0d expected 0", exp1.size(), exp0.size());
      exp1.delete();
      exp0.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({in_ready1, out_valid1, out_data1, out_flags1} !== 20'h0 ||
        {in_ready0, out_valid0, out_data0, out_flags0} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_state got %b%b_%h_%b expected 0_0_0000_000",
               in_ready1, out_valid1, out_data1, out_flags1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(32'h3F800000);
    send(32'h3F808000);
    send(32'h3F818000);
    send(32'hBF808001);
    drain();
  endtask

  task automatic test_specials();
    send(32'h7F7FFFFF);
    send(32'hFF800000);
    send(32'h7F800001);
    send(32'h80000000);
    send(32'hFFC12345);
    send(32'h00000000);
    drain();
  endtask

  task automatic test_denormals();
    send(32'h00400000);
    send(32'h007FFFFF);
    send(32'h80008000);
    send(32'h00018000);
    drain();
  endtask

  task automatic test_backpressure();
    logic [18:0] hold;
    pop_cyc.delete();
    out_ready = 1'b0;
    send(32'h40490FDB);
    send(32'hC0000001);
    hold = exp1[0];
    in_valid = 1'b1;
    in_data  = 32'h3F808000;
    repeat (5) begin
      @(negedge clk);
      vectors++;
      if (in_ready1 !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_in_ready got %b expected 0", in_ready1);
      end
      vectors++;
      if (out_valid1 !== 1'b1 || {out_flags1, out_data1} !== hold) begin
        miscompares++;
        $display("FAIL bp_hold got %b %h/%b expected 1 %h/%b",
                 out_valid1, out_data1, out_flags1, hold[15:0], hold[18:16]);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h3F808000);
    send(32'h7F7FFFFF);
    drain();
    vectors++;
    if (pop_cyc.size() != 4) begin
      miscompares++;
      $display("FAIL bp_count got %0d expected 4", pop_cyc.size());
    end
  endtask

  task automatic test_back_to_back();
    int first;
    pop_cyc.delete();
    out_ready = 1'b1;
    send(32'h3F800000);
    first = last_acc_cyc;
    for (int i = 1; i < 16; i++) begin
      logic [31:0] v;
      v = $urandom();
      if (i % 5 == 0) v[30:23] = 8'h00;
      if (i % 7 == 0) v[30:23] = 8'hFF;
      send(v);
    end
    drain();
    vectors++;
    if (last_acc_cyc != first + 15) begin
      miscompares++;
      $display("FAIL b2b_accept got %0d expected %0d", last_acc_cyc - first, 15);
    end
    vectors++;
    if (pop_cyc.size() != 16 || pop_cyc[0] != first + 2) begin
      miscompares++;
      $display("FAIL b2b_latency got %0d outputs first at +%0d expected 16 at +2",
               pop_cyc.size(), (pop_cyc.size() > 0) ? pop_cyc[0] - first : -1);
    end else begin
      for (int i = 1; i < 16; i++) begin
        vectors++;
        if (pop_cyc[i] != pop_cyc[i-1] + 1) begin
          miscompares++;
          $display("FAIL b2b_rate gap got %0d expected 1 at %0d", pop_cyc[i] - pop_cyc[i-1], i);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    send(32'h3F800000);
    send(32'hBF818000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({in_ready1, out_valid1, out_data1, out_flags1} !== 20'h0 ||
        {out_valid0, out_data0, out_flags0} !== 20'h0) begin
      miscompares++;
      $display("FAIL mid_reset got %b%b_%h_%b expected 0_0_0000_000",
               in_ready1, out_valid1, out_data1, out_flags1);
    end
    exp1.delete();
    exp0.delete();
    pop_cyc.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (pop_cyc.size() != 0 || out_valid1 !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_ghost got %0d outputs expected 0", pop_cyc.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_specials();
    test_denormals();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp32_to_bf16_conv.md
Name: fp32_to_bf16_conv

Overview:
- Streaming narrowing converter from FP32 to BFloat16, the return path for the bf16 multiplier's FP32 products.
- Lets accumulated FP32 results be written back into bf16 operand storage.
- Two-stage valid/ready pipeline with round-to-nearest-even (RNE), special-case handling and exception flags.
- Sits between the FP32 accumulator output and the bf16 writeback buffer.

Parameters:
- FTZ, 1: 1 = FP32 denormal inputs flush to signed zero; 0 = denormals are rounded with RNE like normal inputs.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data is valid
- in_ready  out  1  converter accepts in_data this cycle
- in_data  in  32  FP32 operand
- out_valid  out  1  out_data and out_flags are valid
- out_ready  in  1  downstream accepts the output
- out_data  out  16  BFloat16 result
- out_flags  out  3  {nan, overflow, inexact}

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset:
  - out_valid=0, out_data=16'h0000, out_flags=3'b000.
  - Both stage valid bits clear; any in-flight data is discarded.
  - in_ready=0 while rst=1.
- Handshake:
  - A transfer occurs when valid and ready are both 1 on a rising edge.
  - in_ready = ~v1 | ~v2 | out_ready. This is the only combinational in-to-out path.
  - in_data/in_valid never combinationally reach out_*.
  - out_data and out_flags hold stable while out_valid=1 and out_ready=0.
- Pipeline:
  - S1 registers the operand.
  - The rounding core operates between S1 and S2; S2 is the output register.
  - Latency is 2 cycles from accept to out_valid.
  - Throughput is 1 per cycle when out_ready=1.
  - A stage loads when it is empty or the next stage is advancing.
  - A simultaneous accept and output in the same cycle is legal and loses no data.
  - The block holds at most 2 items; no skid beyond that.
- Fields: s=A[31], e=A[30:23], f=A[22:0].
- RNE:
  - lsb=A[16], guard=A[15], sticky=|A[14:0].
  - rup = guard & (sticky | lsb).
  - Result = {s, A[30:16] + rup}; the 15-bit add may carry into the exponent.
  - inexact = guard | sticky.
- Classification, in priority order:
  - NaN (e=FF, f!=0): out = {s, 8'hFF, 1'b1, A[21:16]} (quieted, payload truncated). nan=1, inexact=0.
  - Inf (e=FF, f=0): out = {s, 8'hFF, 7'h00}. No flags set.
  - Zero (e=0, f=0): out = {s, 15'h0}. No flags set.
  - Denormal (e=0, f!=0) with FTZ=1: out = {s, 15'h0}, inexact=1.
  - Denormal with FTZ=0: RNE path. Rounding may carry into a normal exponent (e.g. 0x007FFFFF -> 0x0080).
  - Normal: RNE path. If the rounded exponent becomes FF, the result is {s, 8'hFF, 7'h00} with overflow=1 and inexact=1.
- Back-to-back inputs with mixed classes must not cross-contaminate flags; flags are registered alongside each data item.

Decomposition:
- Package bf16_pkg holds:
  - EXP_ALL_ONES=8'hFF
  - BF16_QNAN_BIT=6 (bit index of the quiet bit in the 7-bit fraction)
  - flag bit indices FLG_NAN=2, FLG_OVF=1, FLG_INX=0
  - FP32/BF16 field-width localparams
- One combinational sub-module, fp32_to_bf16_round (classify + RNE + flags). The top level owns the 2-stage valid/ready pipeline.

Test Plan:
- Basic and tie cases, out_ready=1: 0x3F800000 -> 0x3F80, flags 000; 0x3F808000 (tie, lsb=0) -> 0x3F80, flags 001; 0x3F818000 (tie, lsb=1) -> 0x3F82, flags 001; 0xBF808001 -> 0xBF81, flags 001.
- Overflow and specials: 0x7F7FFFFF -> 0x7F80, flags 011; 0xFF800000 -> 0xFF80, flags 000; 0x7F800001 -> 0x7FC0, flags 100; 0x80000000 -> 0x8000, flags 000.
- Denormals: 0x00400000 with FTZ=1 -> 0x0000, flags 001; 0x007FFFFF with FTZ=0 -> 0x0080, flags 001.
- Backpressure: stream 4 values while out_ready=0 for 5 cycles.
  - in_ready drops after 2 accepts.
  - Outputs stay stable while stalled.
  - After release, all 4 results emerge in order with no loss or duplication.
- Throughput: 16 back-to-back inputs with out_ready=1 -> first out_valid 2 cycles after the first accept, then one result per cycle.
- Reset mid-stream: assert rst with 2 items in flight -> next cycle out_valid=0, out_data=0x0000, out_flags=000; the items never appear.
